// File: rtl/reg_read_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_stage_pkg
//  Description : Shared backend types and sizes for the register-read stage,
//                its physical register file and the Execute-side interface.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_read_stage_pkg;

    localparam int NUM_PIPES = 4;                    // ALU1, ALU2, MUL, AGU
    localparam int NUM_WB    = 3;                    // writeback ports from Execute
    localparam int NUM_PREGS = 64;                   // physical registers
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int XLEN      = 32;
    localparam int OPC_W     = 8;

    typedef logic [PREG_W-1:0] preg_t;

    // Uop handed to Execute; layout matches the Execute-side struct
    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [XLEN-1:0]  src1_val;
        logic [XLEN-1:0]  src2_val;
        preg_t            pdst;
    } rr_ex_uop_t;

    // One writeback port from Execute
    typedef struct packed {
        logic            en;
        preg_t           preg;
        logic [XLEN-1:0] data;
    } wb_t;

    // Operand value as seen at the accept edge: preg 0 is hard zero, then the
    // highest-index matching writeback, then the register file read value.
    function automatic logic [XLEN-1:0] resolve_operand(
        input preg_t                  i_preg,
        input wb_t [NUM_WB-1:0]       i_wb,
        input logic [XLEN-1:0]        i_rf_val
    );
        logic [XLEN-1:0] v_val;
        v_val = i_rf_val;
        // Ascending scan so the highest-index match is the one that sticks
        for (int w = 0; w < NUM_WB; w++) begin
            if (i_wb[w].en && (i_wb[w].preg == i_preg)) begin
                v_val = i_wb[w].data;
            end
        end
        if (i_preg == '0) begin
            v_val = '0;
        end
        return v_val;
    endfunction

endpackage : reg_read_stage_pkg
`default_nettype wire

// File: rtl/reg_read_stage_prf.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_file
//  Description : NUM_PREGS x XLEN physical register file. NUM_WB synchronous
//                write ports (highest index wins on collision, preg 0 writes
//                dropped) and NUM_RD asynchronous read ports (preg 0 reads 0).
//                Storage is intentionally not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module phys_reg_file
    import reg_read_stage_pkg::*;
#(
    parameter int NUM_RD = 2 * NUM_PIPES
) (
    input  logic                           clk,
    input  wb_t   [NUM_WB-1:0]             i_wb,
    input  preg_t [NUM_RD-1:0]             i_rd_preg,
    output logic  [NUM_RD-1:0][XLEN-1:0]   o_rd_data
);

    logic [XLEN-1:0] r_mem [NUM_PREGS];

    // Write ports applied in ascending order so the highest index lands last
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WB; w++) begin
            if (i_wb[w].en && (i_wb[w].preg != '0)) begin
                r_mem[i_wb[w].preg] <= i_wb[w].data;
            end
        end
    end

    // Asynchronous reads; entry 0 is never written, so force it to zero here
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            if (i_rd_preg[r] == '0) begin
                o_rd_data[r] = '0;
            end else begin
                o_rd_data[r] = r_mem[i_rd_preg[r]];
            end
        end
    end

endmodule : phys_reg_file
`default_nettype wire

// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_stage
//  Description : Register-read stage feeding the four execute pipes. Reads
//                operands from the owned physical register file, bypasses
//                same-cycle writebacks, and registers each uop into a per-pipe
//                output slot with a valid/ready handshake toward Execute.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,          // asynchronous, active-low
    input  logic                          flush,
    // Issue side
    input  logic [NUM_PIPES-1:0]          iss_valid,
    output logic [NUM_PIPES-1:0]          iss_ready,
    input  logic [NUM_PIPES*OPC_W-1:0]    iss_opc,
    input  logic [NUM_PIPES*PREG_W-1:0]   iss_psrc1,
    input  logic [NUM_PIPES*PREG_W-1:0]   iss_psrc2,
    input  logic [NUM_PIPES*PREG_W-1:0]   iss_pdst,
    input  logic [NUM_PIPES*XLEN-1:0]     iss_imm,
    input  logic [NUM_PIPES-1:0]          iss_use_imm,
    // Writeback side
    input  logic [NUM_WB-1:0]             wb_en,
    input  logic [NUM_WB*PREG_W-1:0]      wb_preg,
    input  logic [NUM_WB*XLEN-1:0]        wb_data,
    // Execute side
    output logic [NUM_PIPES-1:0]          ex_valid,
    input  logic [NUM_PIPES-1:0]          ex_ready,
    output logic [NUM_PIPES*OPC_W-1:0]    ex_opc,
    output logic [NUM_PIPES*XLEN-1:0]     ex_src1_val,
    output logic [NUM_PIPES*XLEN-1:0]     ex_src2_val,
    output logic [NUM_PIPES*PREG_W-1:0]   ex_pdst
);

    localparam int NUM_RD = 2 * NUM_PIPES;

    wb_t   [NUM_WB-1:0]            w_wb;
    preg_t [NUM_RD-1:0]            w_rd_preg;
    logic  [NUM_RD-1:0][XLEN-1:0]  w_rd_data;

    // Gather the flat writeback buses into per-port structs
    always_comb begin
        for (int w = 0; w < NUM_WB; w++) begin
            w_wb[w].en   = wb_en[w];
            w_wb[w].preg = wb_preg[w*PREG_W +: PREG_W];
            w_wb[w].data = wb_data[w*XLEN +: XLEN];
        end
    end

    // Read port 2p serves src1 of pipe p, port 2p+1 serves src2
    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            w_rd_preg[2*p]   = iss_psrc1[p*PREG_W +: PREG_W];
            w_rd_preg[2*p+1] = iss_psrc2[p*PREG_W +: PREG_W];
        end
    end

    phys_reg_file #(
        .NUM_RD    (NUM_RD)
    ) u_prf (
        .clk       (clk),
        .i_wb      (w_wb),
        .i_rd_preg (w_rd_preg),
        .o_rd_data (w_rd_data)
    );

    generate
        for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
            rr_ex_uop_t w_uop;
            rr_ex_uop_t r_slot;
            logic       r_valid;
            logic       w_ready;
            logic       w_accept;
            preg_t      w_psrc1;
            preg_t      w_psrc2;

            assign w_psrc1  = iss_psrc1[p*PREG_W +: PREG_W];
            assign w_psrc2  = iss_psrc2[p*PREG_W +: PREG_W];

            // Slot can take a new uop if it is empty or being drained this cycle
            assign w_ready  = !r_valid || ex_ready[p];
            assign w_accept = iss_valid[p] && w_ready;

            // Operand capture with writeback bypass; imm replaces src2 when selected
            always_comb begin
                w_uop.opc      = iss_opc[p*OPC_W +: OPC_W];
                w_uop.pdst     = iss_pdst[p*PREG_W +: PREG_W];
                w_uop.src1_val = resolve_operand(w_psrc1, w_wb, w_rd_data[2*p]);
                if (iss_use_imm[p]) begin
                    w_uop.src2_val = iss_imm[p*XLEN +: XLEN];
                end else begin
                    w_uop.src2_val = resolve_operand(w_psrc2, w_wb, w_rd_data[2*p+1]);
                end
            end

            // Output slot: flush beats accept, accept beats pop, otherwise hold
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_slot  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_slot  <= w_uop;
                end else if (ex_ready[p]) begin
                    r_valid <= 1'b0;
                end
            end

            assign iss_ready[p]                     = w_ready;
            assign ex_valid[p]                      = r_valid;
            assign ex_opc[p*OPC_W +: OPC_W]         = r_slot.opc;
            assign ex_src1_val[p*XLEN +: XLEN]      = r_slot.src1_val;
            assign ex_src2_val[p*XLEN +: XLEN]      = r_slot.src2_val;
            assign ex_pdst[p*PREG_W +: PREG_W]      = r_slot.pdst;
        end
    endgenerate

endmodule : reg_read_stage
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_read_stage
//  Description : Self-checking bench for reg_read_stage: directed scenarios
//                followed by random traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_read_stage;
    import reg_read_stage_pkg::*;

    logic                          clk;
    logic                          rst;
    logic                          flush;
    logic [NUM_PIPES-1:0]          iss_valid;
    logic [NUM_PIPES-1:0]          iss_ready;
    logic [NUM_PIPES*OPC_W-1:0]    iss_opc;
    logic [NUM_PIPES*PREG_W-1:0]   iss_psrc1;
    logic [NUM_PIPES*PREG_W-1:0]   iss_psrc2;
    logic [NUM_PIPES*PREG_W-1:0]   iss_pdst;
    logic [NUM_PIPES*XLEN-1:0]     iss_imm;
    logic [NUM_PIPES-1:0]          iss_use_imm;
    logic [NUM_WB-1:0]             wb_en;
    logic [NUM_WB*PREG_W-1:0]      wb_preg;
    logic [NUM_WB*XLEN-1:0]        wb_data;
    logic [NUM_PIPES-1:0]          ex_valid;
    logic [NUM_PIPES-1:0]          ex_ready;
    logic [NUM_PIPES*OPC_W-1:0]    ex_opc;
    logic [NUM_PIPES*XLEN-1:0]     ex_src1_val;
    logic [NUM_PIPES*XLEN-1:0]     ex_src2_val;
    logic [NUM_PIPES*PREG_W-1:0]   ex_pdst;

    reg_read_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_opc     (iss_opc),
        .iss_psrc1   (iss_psrc1),
        .iss_psrc2   (iss_psrc2),
        .iss_pdst    (iss_pdst),
        .iss_imm     (iss_imm),
        .iss_use_imm (iss_use_imm),
        .wb_en       (wb_en),
        .wb_preg     (wb_preg),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_opc      (ex_opc),
        .ex_src1_val (ex_src1_val),
        .ex_src2_val (ex_src2_val),
        .ex_pdst     (ex_pdst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents and the uop each pipe holds
    logic [XLEN-1:0]   m_rf   [NUM_PREGS];
    logic              m_valid[NUM_PIPES];
    logic [OPC_W-1:0]  m_opc  [NUM_PIPES];
    logic [XLEN-1:0]   m_s1   [NUM_PIPES];
    logic [XLEN-1:0]   m_s2   [NUM_PIPES];
    logic [PREG_W-1:0] m_pdst [NUM_PIPES];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_iss(input int p, input logic [7:0] opc, input logic [5:0] ps1,
                           input logic [5:0] ps2, input logic [5:0] pd,
                           input logic [31:0] imm, input logic use_imm, input logic vld);
        iss_opc[p*OPC_W +: OPC_W]     = opc;
        iss_psrc1[p*PREG_W +: PREG_W] = ps1;
        iss_psrc2[p*PREG_W +: PREG_W] = ps2;
        iss_pdst[p*PREG_W +: PREG_W]  = pd;
        iss_imm[p*XLEN +: XLEN]       = imm;
        iss_use_imm[p]                = use_imm;
        iss_valid[p]                  = vld;
    endtask

    task automatic set_wb(input int w, input logic en, input logic [5:0] preg, input logic [31:0] data);
        wb_en[w]                    = en;
        wb_preg[w*PREG_W +: PREG_W] = preg;
        wb_data[w*XLEN +: XLEN]     = data;
    endtask

    // One clock with the currently driven inputs; model and DUT compared on both sides of the edge
    task automatic cycle();
        logic [XLEN-1:0] new_rf[NUM_PREGS];
        logic [5:0]      pr;
        #1;
        for (int p = 0; p < NUM_PIPES; p++) begin
            check($sformatf("iss_ready%0d", p), iss_ready[p], !m_valid[p] || ex_ready[p]);
        end
        // Register contents after this edge's writes; an operand read at accept sees exactly this
        new_rf = m_rf;
        for (int w = 0; w < NUM_WB; w++) begin
            pr = wb_preg[w*PREG_W +: PREG_W];
            if (wb_en[w] && pr != 0) new_rf[pr] = wb_data[w*XLEN +: XLEN];
        end
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (flush) begin
                m_valid[p] = 1'b0;
            end else if (iss_valid[p] && (!m_valid[p] || ex_ready[p])) begin
                m_valid[p] = 1'b1;
                m_opc[p]   = iss_opc[p*OPC_W +: OPC_W];
                m_pdst[p]  = iss_pdst[p*PREG_W +: PREG_W];
                m_s1[p]    = new_rf[iss_psrc1[p*PREG_W +: PREG_W]];
                m_s2[p]    = iss_use_imm[p] ? iss_imm[p*XLEN +: XLEN]
                                            : new_rf[iss_psrc2[p*PREG_W +: PREG_W]];
            end else if (ex_ready[p]) begin
                m_valid[p] = 1'b0;
            end
        end
        @(posedge clk);
        m_rf = new_rf;
        #1;
        for (int p = 0; p < NUM_PIPES; p++) begin
            check($sformatf("ex_valid%0d", p), ex_valid[p], m_valid[p]);
            if (m_valid[p]) begin
                check($sformatf("ex_opc%0d", p),  ex_opc[p*OPC_W +: OPC_W],   m_opc[p]);
                check($sformatf("ex_src1_%0d", p), ex_src1_val[p*XLEN +: XLEN], m_s1[p]);
                check($sformatf("ex_src2_%0d", p), ex_src2_val[p*XLEN +: XLEN], m_s2[p]);
                check($sformatf("ex_pdst%0d", p), ex_pdst[p*PREG_W +: PREG_W], m_pdst[p]);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int p = 0; p < NUM_PIPES; p++) begin
            check($sformatf("%s_valid%0d", tag, p), ex_valid[p], 1'b0);
            check($sformatf("%s_opc%0d", tag, p),   ex_opc[p*OPC_W +: OPC_W], '0);
            check($sformatf("%s_src1_%0d", tag, p), ex_src1_val[p*XLEN +: XLEN], '0);
            check($sformatf("%s_src2_%0d", tag, p), ex_src2_val[p*XLEN +: XLEN], '0);
            check($sformatf("%s_pdst%0d", tag, p),  ex_pdst[p*PREG_W +: PREG_W], '0);
        end
    endtask

    // Absolute time bound on the whole run
    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0;
        iss_valid = '0; iss_opc = '0; iss_psrc1 = '0; iss_psrc2 = '0; iss_pdst = '0;
        iss_imm = '0; iss_use_imm = '0; wb_en = '0; wb_preg = '0; wb_data = '0;
        ex_ready = '1;
        for (int i = 0; i < NUM_PREGS; i++) m_rf[i] = 'x;
        m_rf[0] = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            m_valid[p] = 1'b0; m_opc[p] = '0; m_s1[p] = '0; m_s2[p] = '0; m_pdst[p] = '0;
        end

        // Reset state, before any clock edge
        #2;
        check_reset_vals("rst");
        check("rst_iss_ready", iss_ready, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill the whole register file with random data
        for (int i = 1; i < NUM_PREGS; i += NUM_WB) begin
            for (int w = 0; w < NUM_WB; w++) begin
                set_wb(w, (i + w) < NUM_PREGS, 6'((i + w) % NUM_PREGS), $urandom);
            end
            cycle();
        end
        wb_en = '0;

        // Basic read after write
        set_wb(0, 1'b1, 6'd5, 32'hDEADBEEF);
        cycle();
        wb_en = '0;
        set_iss(0, 8'h11, 6'd5, 6'd0, 6'd7, 32'h0, 1'b0, 1'b1);
        cycle();
        check("basic_valid", ex_valid[0], 1'b1);
        check("basic_src1", ex_src1_val[31:0], 32'hDEADBEEF);
        check("basic_src2", ex_src2_val[31:0], 32'h0);
        iss_valid = '0;

        // Same-cycle bypass, then two-port collision on the same preg
        set_wb(2, 1'b1, 6'd9, 32'h1234);
        set_iss(2, 8'h21, 6'd9, 6'd0, 6'd8, 32'h0, 1'b0, 1'b1);
        cycle();
        check("bypass_src1", ex_src1_val[2*XLEN +: XLEN], 32'h1234);
        wb_en = '0;
        set_wb(0, 1'b1, 6'd9, 32'hA);
        set_wb(1, 1'b1, 6'd9, 32'hB);
        cycle();
        check("collide_bypass", ex_src1_val[2*XLEN +: XLEN], 32'hB);
        wb_en = '0;
        set_iss(2, 8'h22, 6'd9, 6'd9, 6'd8, 32'h0, 1'b0, 1'b1);
        cycle();
        check("collide_stored1", ex_src1_val[2*XLEN +: XLEN], 32'hB);
        check("collide_stored2", ex_src2_val[2*XLEN +: XLEN], 32'hB);
        iss_valid = '0;
        cycle();

        // Backpressure on pipe 1: hold three cycles, then same-cycle refill and back-to-back
        ex_ready[1] = 1'b0;
        set_iss(1, 8'h31, 6'd3, 6'd4, 6'd10, 32'h0, 1'b0, 1'b1);
        cycle();
        check("bp_first_pdst", ex_pdst[1*PREG_W +: PREG_W], 6'd10);
        set_iss(1, 8'h32, 6'd6, 6'd7, 6'd11, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_ready", iss_ready[1], 1'b0);
            cycle();
            check("bp_stall_pdst", ex_pdst[1*PREG_W +: PREG_W], 6'd10);
        end
        ex_ready[1] = 1'b1;
        #1;
        check("bp_release_ready", iss_ready[1], 1'b1);
        cycle();
        check("bp_refill_pdst", ex_pdst[1*PREG_W +: PREG_W], 6'd11);
        set_iss(1, 8'h33, 6'd8, 6'd9, 6'd12, 32'h0, 1'b0, 1'b1);
        cycle();
        check("bp_b2b_valid", ex_valid[1], 1'b1);
        check("bp_b2b_pdst", ex_pdst[1*PREG_W +: PREG_W], 6'd12);
        iss_valid = '0;
        cycle();

        // Immediate operand and the zero register
        set_iss(3, 8'h41, 6'd0, 6'd17, 6'd13, 32'hFFFFFFF0, 1'b1, 1'b1);
        cycle();
        check("imm_src1", ex_src1_val[3*XLEN +: XLEN], 32'h0);
        check("imm_src2", ex_src2_val[3*XLEN +: XLEN], 32'hFFFFFFF0);
        iss_valid = '0;
        set_wb(0, 1'b1, 6'd0, 32'h55);
        cycle();
        wb_en = '0;
        set_iss(3, 8'h42, 6'd0, 6'd0, 6'd14, 32'h0, 1'b0, 1'b1);
        cycle();
        check("zero_src1", ex_src1_val[3*XLEN +: XLEN], 32'h0);
        check("zero_src2", ex_src2_val[3*XLEN +: XLEN], 32'h0);
        iss_valid = '0;

        // Flush with all slots held and new issues arriving
        ex_ready = '0;
        for (int p = 0; p < NUM_PIPES; p++) set_iss(p, 8'(8'h50 + p), 6'(p + 1), 6'(p + 2), 6'(p + 20), $urandom, 1'b0, 1'b1);
        cycle();
        check("flush_pre_valid", ex_valid, 4'hF);
        ex_ready = '1;
        flush = 1'b1;
        set_wb(1, 1'b1, 6'd20, 32'h77);
        cycle();
        check("flush_valid", ex_valid, 4'h0);
        flush = 1'b0;
        wb_en = '0;
        iss_valid = '0;
        set_iss(0, 8'h60, 6'd20, 6'd0, 6'd1, 32'h0, 1'b0, 1'b1);
        cycle();
        check("flush_wb_kept", ex_src1_val[31:0], 32'h77);
        iss_valid = '0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                set_iss(p, 8'($urandom), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                        6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 9) < 7));
                ex_ready[p] = 1'($urandom_range(0, 3) != 0);
            end
            for (int w = 0; w < NUM_WB; w++) begin
                set_wb(w, 1'($urandom_range(0, 9) < 6), 6'($urandom_range(0, 63)), $urandom);
            end
            flush = 1'($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;
        wb_en = '0;
        iss_valid = '0;

        // Asynchronous reset while every slot is stalled
        ex_ready = '0;
        for (int p = 0; p < NUM_PIPES; p++) set_iss(p, 8'(8'h70 + p), 6'(p + 30), 6'(p + 40), 6'(p + 50), $urandom, 1'b0, 1'b1);
        cycle();
        iss_valid = '0;
        cycle();
        check("areset_pre_valid", ex_valid, 4'hF);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("areset");
        for (int p = 0; p < NUM_PIPES; p++) m_valid[p] = 1'b0;
        #1;
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_read_stage
`default_nettype wire
